// File: rtl/mf8_alu.sv
// mf8 execute/writeback stage: AVR-style 8-bit ALU, SREG, and two-beat 16-bit writes.
// Define MF8_MUL_EN to include the unsigned 8x8 MUL (op 26); otherwise op 26 is a NOP.
module mf8_alu #(
  parameter logic [7:0] SREG_INIT = 8'h00
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Op_Valid,
  input  logic [4:0] Op,
  input  logic [7:0] Rd_Data,
  input  logic [7:0] Rr_Data,
  input  logic [7:0] K,
  output logic       Wr,
  output logic [7:0] Data_Out,
  output logic       Busy,
  output logic       Addr_Hi,
  output logic [7:0] SREG
);

  localparam logic [4:0] OP_ADD  = 5'd0,  OP_ADC  = 5'd1,  OP_SUB  = 5'd2,  OP_SBC  = 5'd3;
  localparam logic [4:0] OP_AND  = 5'd4,  OP_OR   = 5'd5,  OP_EOR  = 5'd6,  OP_MOV  = 5'd7;
  localparam logic [4:0] OP_INC  = 5'd8,  OP_DEC  = 5'd9,  OP_COM  = 5'd10, OP_NEG  = 5'd11;
  localparam logic [4:0] OP_LSR  = 5'd12, OP_ROR  = 5'd13, OP_ASR  = 5'd14, OP_SWAP = 5'd15;
  localparam logic [4:0] OP_SUBI = 5'd16, OP_SBCI = 5'd17, OP_CP   = 5'd18, OP_CPC  = 5'd19;
  localparam logic [4:0] OP_CPI  = 5'd20, OP_LDI  = 5'd21, OP_ADIW = 5'd22, OP_SBIW = 5'd23;
  localparam logic [4:0] OP_BSET = 5'd24, OP_BCLR = 5'd25;
`ifdef MF8_MUL_EN
  localparam logic [4:0] OP_MUL  = 5'd26;
`endif

  localparam int FC = 0, FZ = 1, FN = 2, FV = 3, FS = 4, FH = 5;

  typedef enum logic {IDLE, HI} state_t;

  state_t     state_q;
  logic [7:0] sreg_q, sreg_d;
  logic       busy_q, addr_hi_q;
  logic       hi_c_q, hi_sub_q, lo_zero_q;
`ifdef MF8_MUL_EN
  logic       hi_mul_q;
  logic [7:0] prod_hi_q;
  logic [15:0] product;
  assign product = Rd_Data * Rr_Data;
`endif

  logic [7:0] op_b, add_a, add_b, res;
  logic       add_ci, add_sub;
  logic [8:0] sum9;
  logic       add_h, add_v;
  logic       wr_c, nzs, zchain, wide_start;

  always_comb begin
    op_b = (Op == OP_SUBI || Op == OP_SBCI || Op == OP_CPI || Op == OP_LDI) ? K : Rr_Data;
    add_a   = Rd_Data;
    add_b   = op_b;
    add_ci  = 1'b0;
    add_sub = 1'b0;
    case (Op)
      OP_ADC:                          add_ci = sreg_q[FC];
      OP_SUB, OP_SUBI, OP_CP, OP_CPI:  add_sub = 1'b1;
      OP_SBC, OP_SBCI, OP_CPC: begin add_sub = 1'b1; add_ci = sreg_q[FC]; end
      OP_INC:                          add_b = 8'h01;
      OP_DEC:  begin add_b = 8'h01; add_sub = 1'b1; end
      OP_NEG:  begin add_a = 8'h00; add_b = Rd_Data; add_sub = 1'b1; end
      OP_ADIW:                         add_b = {2'b00, K[5:0]};
      OP_SBIW: begin add_b = {2'b00, K[5:0]}; add_sub = 1'b1; end
      default: ;
    endcase
    // High beat of ADIW/SBIW just propagates the latched carry/borrow.
    if (state_q == HI) begin
      add_a   = Rd_Data;
      add_b   = 8'h00;
      add_ci  = hi_c_q;
      add_sub = hi_sub_q;
    end

    if (add_sub) begin
      sum9  = {1'b0, add_a} - {1'b0, add_b} - {8'h00, add_ci};
      add_h = {1'b0, add_a[3:0]} < ({1'b0, add_b[3:0]} + {4'h0, add_ci});
      add_v = (add_a[7] != add_b[7]) && (sum9[7] != add_a[7]);
    end else begin
      sum9  = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_ci};
      add_h = ({1'b0, add_a[3:0]} + {1'b0, add_b[3:0]} + {4'h0, add_ci}) > 5'd15;
      add_v = (add_a[7] == add_b[7]) && (sum9[7] != add_a[7]);
    end

    res        = 8'h00;
    wr_c       = 1'b0;
    sreg_d     = sreg_q;
    nzs        = 1'b0;
    zchain     = 1'b0;
    wide_start = 1'b0;

    if (state_q == HI) begin
      wr_c       = 1'b1;
      res        = sum9[7:0];
      sreg_d[FC] = sum9[8];
      sreg_d[FV] = add_v;
      sreg_d[FN] = res[7];
      sreg_d[FS] = res[7] ^ add_v;
      sreg_d[FZ] = lo_zero_q & (res == 8'h00);
`ifdef MF8_MUL_EN
      if (hi_mul_q) begin
        res        = prod_hi_q;
        sreg_d     = sreg_q;
        sreg_d[FC] = prod_hi_q[7];
        sreg_d[FZ] = lo_zero_q & (prod_hi_q == 8'h00);
      end
`endif
    end else if (Op_Valid) begin
      case (Op)
        OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_SUBI, OP_SBCI, OP_CP, OP_CPC, OP_CPI, OP_NEG: begin
          res        = sum9[7:0];
          wr_c       = !(Op == OP_CP || Op == OP_CPC || Op == OP_CPI);
          sreg_d[FH] = add_h;
          sreg_d[FV] = add_v;
          sreg_d[FC] = sum9[8];
          zchain     = (Op == OP_SBC || Op == OP_SBCI || Op == OP_CPC);
          nzs        = 1'b1;
        end
        OP_AND, OP_OR, OP_EOR: begin
          res        = (Op == OP_AND) ? (Rd_Data & op_b) :
                       (Op == OP_OR)  ? (Rd_Data | op_b) : (Rd_Data ^ op_b);
          wr_c       = 1'b1;
          sreg_d[FV] = 1'b0;
          nzs        = 1'b1;
        end
        OP_INC, OP_DEC: begin
          res        = sum9[7:0];
          wr_c       = 1'b1;
          sreg_d[FV] = (Op == OP_INC) ? (res == 8'h80) : (res == 8'h7F);
          nzs        = 1'b1;
        end
        OP_COM: begin
          res        = ~Rd_Data;
          wr_c       = 1'b1;
          sreg_d[FC] = 1'b1;
          sreg_d[FV] = 1'b0;
          nzs        = 1'b1;
        end
        OP_LSR, OP_ROR, OP_ASR: begin
          res        = {(Op == OP_ROR) ? sreg_q[FC] : (Op == OP_ASR) ? Rd_Data[7] : 1'b0,
                        Rd_Data[7:1]};
          wr_c       = 1'b1;
          sreg_d[FC] = Rd_Data[0];
          sreg_d[FV] = res[7] ^ Rd_Data[0];
          nzs        = 1'b1;
        end
        OP_SWAP: begin res = {Rd_Data[3:0], Rd_Data[7:4]}; wr_c = 1'b1; end
        OP_MOV:  begin res = Rr_Data; wr_c = 1'b1; end
        OP_LDI:  begin res = K;       wr_c = 1'b1; end
        OP_ADIW, OP_SBIW: begin
          res        = sum9[7:0];
          wr_c       = 1'b1;
          wide_start = 1'b1;
        end
        OP_BSET: sreg_d[K[2:0]] = 1'b1;
        OP_BCLR: sreg_d[K[2:0]] = 1'b0;
`ifdef MF8_MUL_EN
        OP_MUL: begin
          res        = product[7:0];
          wr_c       = 1'b1;
          wide_start = 1'b1;
        end
`endif
        default: ;
      endcase
      if (nzs) begin
        sreg_d[FN] = res[7];
        sreg_d[FZ] = (res == 8'h00) & (zchain ? sreg_q[FZ] : 1'b1);
        sreg_d[FS] = res[7] ^ sreg_d[FV];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      sreg_q    <= SREG_INIT;
      busy_q    <= 1'b0;
      addr_hi_q <= 1'b0;
      hi_c_q    <= 1'b0;
      hi_sub_q  <= 1'b0;
      lo_zero_q <= 1'b0;
`ifdef MF8_MUL_EN
      hi_mul_q  <= 1'b0;
      prod_hi_q <= 8'h00;
`endif
    end else begin
      case (state_q)
        IDLE: if (Op_Valid) begin
          sreg_q <= sreg_d;
          if (wide_start) begin
            state_q   <= HI;
            busy_q    <= 1'b1;
            addr_hi_q <= 1'b1;
            hi_c_q    <= sum9[8];
            hi_sub_q  <= (Op == OP_SBIW);
            lo_zero_q <= (res == 8'h00);
`ifdef MF8_MUL_EN
            hi_mul_q  <= (Op == OP_MUL);
            prod_hi_q <= product[15:8];
`endif
          end
        end
        HI: begin
          sreg_q    <= sreg_d;
          state_q   <= IDLE;
          busy_q    <= 1'b0;
          addr_hi_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Wr       = wr_c & ~Reset;
  assign Data_Out = Reset ? 8'h00 : res;
  assign Busy     = busy_q;
  assign Addr_Hi  = addr_hi_q;
  assign SREG     = sreg_q;

endmodule

// File: tb/tb_mf8_alu.sv
// Self-checking bench for mf8_alu: hand vectors, directed 16-bit/reset sequences, random vs model.
module tb_mf8_alu;
  logic       Clk = 1'b0, Reset, Op_Valid;
  logic [4:0] Op;
  logic [7:0] Rd_Data, Rr_Data, K;
  logic       Wr, Busy, Addr_Hi;
  logic [7:0] Data_Out, SREG;

  mf8_alu dut (.Clk(Clk), .Reset(Reset), .Op_Valid(Op_Valid), .Op(Op), .Rd_Data(Rd_Data),
               .Rr_Data(Rr_Data), .K(K), .Wr(Wr), .Data_Out(Data_Out), .Busy(Busy),
               .Addr_Hi(Addr_Hi), .SREG(SREG));

  always #5 Clk = ~Clk;

  int n_cmp = 0, n_fail = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [4:0] op, input logic [7:0] rd, rr, k,
                       output logic w, output logic [7:0] d);
    @(negedge Clk);
    Op_Valid = 1'b1; Op = op; Rd_Data = rd; Rr_Data = rr; K = k;
    #1; w = Wr; d = Data_Out;
    @(posedge Clk); #1;
  endtask

  // High beat: decoder is not issuing, but drive garbage to show Op_Valid is ignored.
  task automatic hi_cycle(input logic [7:0] rd_hi, output logic w, output logic [7:0] d,
                          output logic b, output logic ah);
    @(negedge Clk);
    Op_Valid = 1'b1; Op = 5'd21; K = 8'h55; Rd_Data = rd_hi;
    #1; w = Wr; d = Data_Out; b = Busy; ah = Addr_Hi;
    @(posedge Clk); #1;
  endtask

  task automatic set_sreg(input logic [7:0] v);
    logic w; logic [7:0] d;
    for (int i = 0; i < 8; i++) issue(v[i] ? 5'd24 : 5'd25, 8'h00, 8'h00, 8'(i), w, d);
  endtask

  function automatic int sx(input int x);
    return (x > 127) ? x - 256 : x;
  endfunction

  // Reference for single-byte ops, from the AVR flag rules in integer arithmetic.
  task automatic model1(input int op, input int rd, input int rr, input int k, input logic [7:0] s,
                        output logic w, output logic [7:0] r, output logic [7:0] ns);
    int b, ci, t, sv; logic nzs, zc;
    b = (op == 16 || op == 17 || op == 20 || op == 21) ? k : rr;
    ci = int'(s[0]); ns = s; w = 1'b0; r = 8'h00; nzs = 1'b0; zc = 1'b0; t = 0; sv = 0;
    case (op)
      0, 1: begin
        if (op == 0) ci = 0;
        t = rd + b + ci; sv = sx(rd) + sx(b) + ci; r = 8'(t);
        ns[0] = t > 255; ns[5] = (rd % 16 + b % 16 + ci) > 15; ns[3] = sv > 127 || sv < -128;
        nzs = 1'b1; w = 1'b1;
      end
      2, 3, 16, 17, 18, 19, 20: begin
        if (op == 2 || op == 16 || op == 18 || op == 20) ci = 0;
        t = rd - b - ci; sv = sx(rd) - sx(b) - ci; r = 8'(t);
        ns[0] = t < 0; ns[5] = (rd % 16 - b % 16 - ci) < 0; ns[3] = sv > 127 || sv < -128;
        nzs = 1'b1; zc = (op == 3 || op == 17 || op == 19); w = (op < 18);
      end
      4, 5, 6: begin
        r = (op == 4) ? 8'(rd & b) : (op == 5) ? 8'(rd | b) : 8'(rd ^ b);
        ns[3] = 1'b0; nzs = 1'b1; w = 1'b1;
      end
      7:  begin r = 8'(rr); w = 1'b1; end
      21: begin r = 8'(k);  w = 1'b1; end
      8:  begin r = 8'((rd + 1) % 256);   ns[3] = (r == 8'h80); nzs = 1'b1; w = 1'b1; end
      9:  begin r = 8'((rd + 255) % 256); ns[3] = (r == 8'h7F); nzs = 1'b1; w = 1'b1; end
      10: begin r = 8'(255 - rd); ns[0] = 1'b1; ns[3] = 1'b0; nzs = 1'b1; w = 1'b1; end
      11: begin
        r = 8'((256 - rd) % 256); ns[0] = (r != 8'h00); ns[3] = (r == 8'h80);
        ns[5] = (rd % 16) != 0; nzs = 1'b1; w = 1'b1;
      end
      12, 13, 14: begin
        r = 8'(rd / 2 + ((op == 13) ? 128 * int'(s[0]) : (op == 14) ? (rd & 128) : 0));
        ns[0] = (rd % 2) == 1; ns[3] = r[7] ^ ns[0]; nzs = 1'b1; w = 1'b1;
      end
      15: begin r = 8'((rd % 16) * 16 + rd / 16); w = 1'b1; end
      24: ns[k % 8] = 1'b1;
      25: ns[k % 8] = 1'b0;
      default: ;
    endcase
    if (nzs) begin
      ns[2] = r[7];
      ns[1] = (r == 8'h00) && (!zc || s[1]);
      ns[4] = ns[2] ^ ns[3];
    end
  endtask

  // 16-bit ADIW/SBIW on the whole word.
  task automatic model16(input logic sub, input int lo, input int hi, input int k6,
                         input logic [7:0] s, output logic [7:0] rlo, rhi, ns);
    int w, t, sw, sv, t16;
    w = hi * 256 + lo; t = sub ? w - k6 : w + k6;
    sw = (w > 32767) ? w - 65536 : w; sv = sub ? sw - k6 : sw + k6;
    t16 = t & 65535; rlo = 8'(t16); rhi = 8'(t16 / 256);
    ns = s;
    ns[0] = sub ? (t < 0) : (t > 65535);
    ns[1] = (t16 == 0); ns[2] = rhi[7]; ns[3] = sv > 32767 || sv < -32768; ns[4] = ns[2] ^ ns[3];
  endtask

  typedef struct {
    logic [4:0] op; logic [7:0] rd, rr, k, s_in; logic wr; logic [7:0] dout, s_out;
  } vec_t;
  vec_t tbl[21];

  initial begin
    logic w, b, ah; logic [7:0] d, ms, elo, ehi, ens, rd, rr, k, hi; int op;
    Reset = 1'b1; Op_Valid = 1'b1; Op = 5'd0; Rd_Data = 8'h7F; Rr_Data = 8'h01; K = 8'h00;

    tbl[0]  = '{5'd1,  8'hFF, 8'h00, 8'h00, 8'h01, 1'b1, 8'h00, 8'h23};
    tbl[1]  = '{5'd2,  8'h10, 8'h20, 8'h00, 8'h00, 1'b1, 8'hF0, 8'h15};
    tbl[2]  = '{5'd3,  8'h80, 8'h01, 8'h00, 8'h02, 1'b1, 8'h7F, 8'h38};
    tbl[3]  = '{5'd4,  8'hF0, 8'h0F, 8'h00, 8'hFF, 1'b1, 8'h00, 8'hE3};
    tbl[4]  = '{5'd6,  8'hAA, 8'h55, 8'h00, 8'h00, 1'b1, 8'hFF, 8'h14};
    tbl[5]  = '{5'd8,  8'h7F, 8'h00, 8'h00, 8'h01, 1'b1, 8'h80, 8'h0D};
    tbl[6]  = '{5'd9,  8'h80, 8'h00, 8'h00, 8'h00, 1'b1, 8'h7F, 8'h18};
    tbl[7]  = '{5'd10, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 8'hFF, 8'h15};
    tbl[8]  = '{5'd11, 8'h80, 8'h00, 8'h00, 8'h00, 1'b1, 8'h80, 8'h0D};
    tbl[9]  = '{5'd12, 8'h01, 8'h00, 8'h00, 8'h04, 1'b1, 8'h00, 8'h1B};
    tbl[10] = '{5'd13, 8'h02, 8'h00, 8'h00, 8'h01, 1'b1, 8'h81, 8'h0C};
    tbl[11] = '{5'd15, 8'h3C, 8'h00, 8'h00, 8'h5A, 1'b1, 8'hC3, 8'h5A};
    tbl[12] = '{5'd16, 8'h05, 8'h99, 8'h05, 8'h00, 1'b1, 8'h00, 8'h02};
    tbl[13] = '{5'd20, 8'h05, 8'h00, 8'h06, 8'h00, 1'b0, 8'h00, 8'h35};
    tbl[14] = '{5'd21, 8'h00, 8'h00, 8'hA7, 8'h3C, 1'b1, 8'hA7, 8'h3C};
    tbl[15] = '{5'd7,  8'h11, 8'h42, 8'h00, 8'h00, 1'b1, 8'h42, 8'h00};
    tbl[16] = '{5'd24, 8'h00, 8'h00, 8'hF9, 8'h00, 1'b0, 8'h00, 8'h02};
    tbl[17] = '{5'd25, 8'h00, 8'h00, 8'h0E, 8'hFF, 1'b0, 8'h00, 8'hBF};
    tbl[18] = '{5'd19, 8'h00, 8'h00, 8'h00, 8'h03, 1'b0, 8'h00, 8'h35};
    tbl[19] = '{5'd27, 8'h12, 8'h34, 8'h00, 8'h5A, 1'b0, 8'h00, 8'h5A};
    tbl[20] = '{5'd17, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00};

    // Reset held with Op_Valid high: no writes, outputs quiet.
    repeat (3) begin
      @(negedge Clk); #1;
      chk("rst wr", Wr, 0); chk("rst dout", Data_Out, 8'h00);
    end
    @(posedge Clk); #1;
    chk("rst sreg", SREG, 8'h00); chk("rst busy", Busy, 0); chk("rst addr_hi", Addr_Hi, 0);
    @(negedge Clk); Reset = 1'b0; Op_Valid = 1'b0;

    issue(5'd0, 8'h7F, 8'h01, 8'h00, w, d);
    chk("add wr", w, 1); chk("add dout", d, 8'h80); chk("add sreg", SREG, 8'h2C);

    issue(5'd2, 8'h10, 8'h10, 8'h00, w, d);
    chk("sub dout", d, 8'h00); chk("sub z", SREG[1], 1);
    issue(5'd19, 8'h00, 8'h00, 8'h00, w, d);
    chk("cpc wr", w, 0); chk("cpc z kept", SREG[1], 1);
    issue(5'd25, 8'h00, 8'h00, 8'h01, w, d);
    issue(5'd19, 8'h00, 8'h00, 8'h00, w, d);
    chk("cpc z stays 0", SREG[1], 0);

    foreach (tbl[i]) begin
      set_sreg(tbl[i].s_in);
      issue(tbl[i].op, tbl[i].rd, tbl[i].rr, tbl[i].k, w, d);
      chk($sformatf("vec%0d wr", i), w, tbl[i].wr);
      if (tbl[i].wr) chk($sformatf("vec%0d dout", i), d, tbl[i].dout);
      chk($sformatf("vec%0d sreg", i), SREG, tbl[i].s_out);
    end

    // ADIW 0x12FF + 1
    set_sreg(8'h03);
    issue(5'd22, 8'hFF, 8'h00, 8'h01, w, d);
    chk("adiw lo wr", w, 1); chk("adiw lo dout", d, 8'h00);
    chk("adiw busy", Busy, 1); chk("adiw addr_hi", Addr_Hi, 1); chk("adiw sreg hold", SREG, 8'h03);
    hi_cycle(8'h12, w, d, b, ah);
    chk("adiw hi wr", w, 1); chk("adiw hi dout", d, 8'h13);
    chk("adiw hi busy", b, 1); chk("adiw hi addr", ah, 1);
    chk("adiw sreg", SREG, 8'h00); chk("adiw busy end", Busy, 0);

    // SBIW 0x0001 - 1, then ASR straight after
    issue(5'd23, 8'h01, 8'h00, 8'h01, w, d);
    chk("sbiw lo dout", d, 8'h00);
    hi_cycle(8'h00, w, d, b, ah);
    chk("sbiw hi wr", w, 1); chk("sbiw hi dout", d, 8'h00); chk("sbiw zc", SREG[1:0], 2'b10);
    issue(5'd14, 8'h81, 8'h00, 8'h00, w, d);
    chk("asr dout", d, 8'hC0); chk("asr sreg", SREG, 8'h15);

    // Reset during the high beat
    set_sreg(8'hA5);
    issue(5'd22, 8'hFF, 8'h00, 8'h01, w, d);
    chk("abort lo wr", w, 1);
    @(negedge Clk);
    Reset = 1'b1; Rd_Data = 8'h12; Op_Valid = 1'b1; Op = 5'd0;
    #1; chk("abort hi wr", Wr, 0);
    @(posedge Clk); #1;
    chk("abort busy", Busy, 0); chk("abort addr", Addr_Hi, 0); chk("abort sreg", SREG, 8'h00);
    repeat (2) begin @(negedge Clk); #1; chk("rst hold wr", Wr, 0); end
    @(negedge Clk); Reset = 1'b0; Op_Valid = 1'b0;
    issue(5'd21, 8'h00, 8'h00, 8'h3C, w, d);
    chk("post abort ldi", {7'd0, w, d}, {7'd0, 1'b1, 8'h3C});

    set_sreg(8'h46);
    issue(5'd26, 8'hFF, 8'hFF, 8'h00, w, d);
`ifdef MF8_MUL_EN
    chk("mul lo wr", w, 1); chk("mul lo dout", d, 8'h01);
    hi_cycle(8'h00, w, d, b, ah);
    chk("mul hi wr", w, 1); chk("mul hi dout", d, 8'hFE); chk("mul sreg", SREG, 8'h45);
`else
    chk("mul nop wr", w, 0); chk("mul nop sreg", SREG, 8'h46); chk("mul nop busy", Busy, 0);
`endif

    set_sreg(8'h00); ms = 8'h00;
    for (int i = 0; i < 400; i++) begin
      op = int'($urandom_range(0, 31));
      rd = 8'($urandom); rr = 8'($urandom); k = 8'($urandom); hi = 8'($urandom);
      if (op == 22 || op == 23) begin
        model16(op == 23, int'(rd), int'(hi), int'(k) % 64, ms, elo, ehi, ens);
        issue(5'(op), rd, rr, k, w, d);
        chk("rnd w lo", {w, d}, {1'b1, elo}); chk("rnd w busy", Busy, 1);
        hi_cycle(hi, w, d, b, ah);
        chk("rnd w hi", {w, b, d}, {2'b11, ehi}); chk("rnd w sreg", SREG, ens);
        ms = ens;
      end
`ifdef MF8_MUL_EN
      else if (op == 26) begin
        elo = 8'((int'(rd) * int'(rr)) % 256); ehi = 8'((int'(rd) * int'(rr)) / 256);
        ens = ms; ens[0] = ehi[7]; ens[1] = (elo == 8'h00) && (ehi == 8'h00);
        issue(5'(op), rd, rr, k, w, d);
        chk("rnd mul lo", {w, d}, {1'b1, elo});
        hi_cycle(8'h00, w, d, b, ah);
        chk("rnd mul hi", {w, d}, {1'b1, ehi}); chk("rnd mul sreg", SREG, ens);
        ms = ens;
      end
`endif
      else begin
        model1(op, int'(rd), int'(rr), int'(k), ms, b, elo, ens);
        issue(5'(op), rd, rr, k, w, d);
        chk($sformatf("rnd op%0d wr", op), w, b);
        if (b) chk($sformatf("rnd op%0d dout", op), d, elo);
        chk($sformatf("rnd op%0d sreg", op), SREG, ens);
        ms = ens;
      end
    end

    @(negedge Clk); Op_Valid = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
